// File: rtl/irq_encoder_ctrl.sv
// Four-line interrupt edge detector with mask, pending register and a
// non-preemptive IDLE/PRESENT grant FSM. Define IRQ_SYNC_EN for a 2-flop input synchronizer.
module irq_encoder_ctrl #(
   parameter logic [3:0] MASK_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] irq,
   input  logic       mask_we,
   input  logic [3:0] mask_d,
   input  logic       ack,
   output logic [3:0] mask,
   output logic [3:0] pend,
   output logic       valid,
   output logic [1:0] y
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t     state;
   logic [3:0] irq_s;
   logic [3:0] irq_d;
   logic [3:0] rise;
   logic [3:0] clr;
   logic [3:0] elig;

`ifdef IRQ_SYNC_EN
   logic [3:0] sync_p0;
   logic [3:0] sync_p1;

   // Synchronizer stages: irq -> sync_p0 -> sync_p1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= irq;
         sync_p1 <= sync_p0;
      end
   end

   assign irq_s = sync_p1;
`else
   assign irq_s = irq;
`endif

   function automatic logic [1:0] prio_enc(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      casez (v)
         4'b1???: idx = 2'd3;
         4'b01??: idx = 2'd2;
         4'b001?: idx = 2'd1;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   assign rise = irq_s & ~irq_d;
   assign elig = pend & ~mask;

   always_comb begin
      clr = '0;
      if (state == PRESENT && ack)
         clr[y] = 1'b1;
   end

   // Edge detect / pending / grant stage; a new rise wins over a same-edge clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d <= '0;
         pend  <= '0;
         mask  <= MASK_RST;
         state <= IDLE;
         valid <= 1'b0;
         y     <= 2'b00;
      end else begin
         irq_d <= irq_s;
         pend  <= (pend & ~clr) | rise;
         if (mask_we)
            mask <= mask_d;
         case (state)
            IDLE: begin
               if (|elig) begin
                  state <= PRESENT;
                  valid <= 1'b1;
                  y     <= prio_enc(elig);
               end
            end
            PRESENT: begin
               if (ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  y     <= 2'b00;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               y     <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_encoder_ctrl.sv
// Self-checking bench for irq_encoder_ctrl: directed scenarios then random traffic
// compared each cycle against a behavioural reference model.
module tb_irq_encoder_ctrl;

   localparam logic [3:0] MASK_RST = 4'b0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] irq;
   logic       mask_we;
   logic [3:0] mask_d;
   logic       ack;
   logic [3:0] mask;
   logic [3:0] pend;
   logic       valid;
   logic [1:0] y;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [3:0] m_mask, m_pend, m_prev, m_s1, m_s2;
   bit         m_busy;
   int         m_y;

   irq_encoder_ctrl #(.MASK_RST(MASK_RST)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq     (irq),
      .mask_we (mask_we),
      .mask_d  (mask_d),
      .ack     (ack),
      .mask    (mask),
      .pend    (pend),
      .valid   (valid),
      .y       (y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mask = MASK_RST;
      m_pend = '0;
      m_prev = '0;
      m_s1   = '0;
      m_s2   = '0;
      m_busy = 1'b0;
      m_y    = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mask"},  mask,  m_mask);
      chk({tag, ".pend"},  pend,  m_pend);
      chk({tag, ".valid"}, {3'b0, valid}, {3'b0, m_busy});
      chk({tag, ".y"},     {2'b0, y}, m_busy ? 4'(m_y) : 4'd0);
   endtask

   // One clock: advance the model from the current inputs, then compare after the edge.
   task automatic tick(input string tag);
      logic [3:0] seen, nxt_pend, elig;
      bit         nxt_busy;
      int         nxt_y;
`ifdef IRQ_SYNC_EN
      seen = m_s2;
`else
      seen = irq;
`endif
      nxt_pend = m_pend;
      nxt_busy = m_busy;
      nxt_y    = m_y;
      if (m_busy && ack) begin
         nxt_pend[m_y] = 1'b0;
         nxt_busy      = 1'b0;
         nxt_y         = 0;
      end
      for (int k = 0; k < 4; k++)
         if (seen[k] && !m_prev[k]) nxt_pend[k] = 1'b1;
      if (!m_busy) begin
         elig = m_pend & ~m_mask;
         for (int k = 0; k < 4; k++)
            if (elig[k]) begin
               nxt_busy = 1'b1;
               nxt_y    = k;
            end
      end
      @(posedge clk);
      if (rst_n) begin
         m_pend = nxt_pend;
         m_busy = nxt_busy;
         m_y    = nxt_y;
         if (mask_we) m_mask = mask_d;
         m_prev = seen;
         m_s2   = m_s1;
         m_s1   = irq;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; irq = '0; mask_we = 1'b0; mask_d = '0; ack = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick("idle0");
      tick("idle1");

      // priority: two lines rise together, higher index granted
      irq = 4'b0101;
      tick("prio_E");
`ifndef IRQ_SYNC_EN
      chk("prio_pend", pend, 4'b0101);
`else
      tick("prio_sync1");
      tick("prio_sync2");
`endif
      tick("prio_E1");
      chk("prio_y", {2'b0, y}, 4'd2);
      tick("prio_hold");

      // ack sequence
      ack = 1'b1;
      tick("ack1");
      ack = 1'b0;
      chk("ack1_pend", pend, 4'b0001);
      chk("ack1_valid", {3'b0, valid}, 4'd0);
      tick("ack1_regrant");
      chk("ack1_y", {2'b0, y}, 4'd0);
      ack = 1'b1;
      tick("ack2");
      ack = 1'b0;
      chk("ack2_pend", pend, 4'b0000);
      irq = '0;
      tick("ack_idle");
      ack = 1'b1;
      tick("ack_in_idle");
      ack = 1'b0;

      // no preemption
      irq = 4'b0010;
      tick("np_set");
      tick("np_grant");
      irq = 4'b1010;
      tick("np_hi");
      tick("np_hold");
      chk("np_y_held", {2'b0, y}, 4'd1);
      ack = 1'b1;
      tick("np_ack");
      ack = 1'b0;
      tick("np_next");
      chk("np_y3", {2'b0, y}, 4'd3);
      ack = 1'b1;
      tick("np_ack2");
      ack = 1'b0;
      irq = '0;
      tick("np_idle");

      // masking
      mask_we = 1'b1; mask_d = 4'b1000;
      tick("mk_wr");
      mask_we = 1'b0;
      irq = 4'b1000;
      tick("mk_set");
      tick("mk_blocked");
      chk("mk_valid0", {3'b0, valid}, 4'd0);
      mask_we = 1'b1; mask_d = 4'b0000;
      tick("mk_clr1");
      mask_we = 1'b0;
      tick("mk_clr2");
      chk("mk_y3", {2'b0, y}, 4'd3);
      ack = 1'b1;
      tick("mk_ack");
      ack = 1'b0;
      irq = '0;
      tick("mk_idle");

      // set/clear collision on the granted line, then reset mid-grant
      irq = 4'b0100;
      tick("co_set");
      tick("co_grant");
      irq = 4'b0000;
      tick("co_low");
      irq = 4'b0100; ack = 1'b1;
      tick("co_hit");
      ack = 1'b0;
      chk("co_pend2", {3'b0, pend[2]}, 4'd1);
      tick("co_regrant");
      chk("co_y2", {2'b0, y}, 4'd2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("abort");
      @(posedge clk); #1;
      check_all("in_reset");

      // line already high at reset release is seen as a rise
      irq = 4'b0001;
      rst_n = 1'b1;
      tick("rel_high");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         irq     = 4'($urandom_range(0, 15));
         mask_we = ($urandom_range(0, 9) == 0);
         mask_d  = 4'($urandom_range(0, 15));
         ack     = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("rnd_rst");
            rst_n = 1'b1;
         end
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
